// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: requester indices,
// default bus widths and the round-robin pointer advance.
package cdb_arbiter_pkg;

    // Requester slots on the CDB
    localparam int CDB_ALU = 0;
    localparam int CDB_LSB = 1;
    localparam int CDB_BR  = 2;

    // Default geometry; the tag width tracks the ROB index width
    localparam int CDB_NUM_REQ = 3;
    localparam int CDB_DEPTH   = 2;
    localparam int CDB_TAG_W   = 4;
    localparam int CDB_DATA_W  = 32;

    // Pointer position just after granted requester g, wrapping over n requesters
    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO. Push is ignored when full, pop when empty.
// Flush empties the FIFO; it takes priority over push and pop.
module cdb_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         empty,
    output logic         full,
    output logic [W-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = en & ~flush & push & ~full;
    assign w_do_pop  = en & ~flush & pop & ~empty;

    // Storage array; contents are don't-care while the slot is not counted
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (en) begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from the ALU, load/store buffer
// and branch unit in small FIFOs and broadcasts one per cycle, round-robin,
// on a registered tag/data bus. Grants are judged on pre-edge FIFO state,
// so a freshly pushed entry is broadcast no earlier than the next edge.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int DEPTH   = CDB_DEPTH,
    parameter int TAG_W   = CDB_TAG_W,
    parameter int DATA_W  = CDB_DATA_W,
    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      Clear_flag,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src,
    output logic [31:0]               conflict_cnt
);

    localparam int ENT_W = TAG_W + DATA_W;

    logic [SRC_W-1:0]   r_rr_ptr;

    logic [NUM_REQ-1:0] w_empty;
    logic [NUM_REQ-1:0] w_full;
    logic [NUM_REQ-1:0] w_nonempty;
    logic [NUM_REQ-1:0] w_push;
    logic [NUM_REQ-1:0] w_pop;
    logic [ENT_W-1:0]   w_head [NUM_REQ];
    logic [ENT_W-1:0]   w_sel_head;
    logic               w_found;
    logic [SRC_W-1:0]   w_gnt;
    logic [SRC_W-1:0]   w_rr_next;
    logic               w_conflict;
    int                 w_idx;
    int                 w_ne_cnt;

    // A full FIFO refuses input even if it is being drained this cycle
    assign req_ready  = {NUM_REQ{rdy}} & ~w_full;
    assign w_push     = req_valid & req_ready;
    assign w_nonempty = ~w_empty;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
        cdb_req_fifo #(
            .DEPTH (DEPTH),
            .W     (ENT_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .en    (rdy),
            .flush (Clear_flag),
            .push  (w_push[i]),
            .pop   (w_pop[i]),
            .din   ({req_tag[i*TAG_W +: TAG_W], req_data[i*DATA_W +: DATA_W]}),
            .empty (w_empty[i]),
            .full  (w_full[i]),
            .head  (w_head[i])
        );
    end

    // Round-robin search: first non-empty FIFO at or after the pointer
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && w_nonempty[w_idx[SRC_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[SRC_W-1:0];
            end
        end
    end

    // Pop the granted FIFO, pick its head and count contending FIFOs
    always_comb begin
        w_pop      = '0;
        w_sel_head = w_head[w_gnt];
        w_rr_next  = SRC_W'(rr_next(int'(w_gnt), NUM_REQ));
        w_ne_cnt   = 0;
        if (w_found && !Clear_flag) begin
            w_pop[w_gnt] = 1'b1;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_nonempty[k]) begin
                w_ne_cnt = w_ne_cnt + 1;
            end
        end
        w_conflict = (w_ne_cnt >= 2);
    end

    // Registered broadcast, pointer and conflict counter; rdy low freezes all
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_data     <= '0;
            cdb_src      <= '0;
            conflict_cnt <= '0;
        end else if (rdy) begin
            if (Clear_flag) begin
                cdb_valid <= 1'b0;
            end else begin
                cdb_valid <= w_found;
                if (w_found) begin
                    cdb_tag  <= w_sel_head[ENT_W-1 -: TAG_W];
                    cdb_data <= w_sel_head[DATA_W-1:0];
                    cdb_src  <= w_gnt;
                    r_rr_ptr <= w_rr_next;
                end
                if (w_conflict) begin
                    conflict_cnt <= conflict_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand-written multi-cycle
// sequences and randomized traffic, all checked against a queue-based model.
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int D  = 2;
    localparam int TW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          Clear_flag;
    logic [N-1:0]  req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic [1:0]    cdb_src;
    logic [31:0]   conflict_cnt;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(N), .DEPTH(D), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .Clear_flag   (Clear_flag),
        .req_valid    (req_valid),
        .req_tag      (req_tag),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_src      (cdb_src),
        .conflict_cnt (conflict_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [TW+DW-1:0] mq [N][$];
    int          m_rr;
    logic        m_v;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    logic [1:0]  m_src;
    logic [31:0] m_cc;

    task automatic model_edge();
        int sz [N];
        int ne;
        int g;
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr = 0; m_v = 0; m_tag = 0; m_data = 0; m_src = 0; m_cc = 0;
        end else if (!rdy) begin
            // frozen
        end else if (Clear_flag) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_v = 0;
        end else begin
            ne = 0;
            for (int i = 0; i < N; i++) begin
                sz[i] = mq[i].size();
                if (sz[i] > 0) ne++;
            end
            if (ne >= 2) m_cc = m_cc + 1;
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && sz[(m_rr + k) % N] > 0) g = (m_rr + k) % N;
            if (g >= 0) begin
                {m_tag, m_data} = mq[g].pop_front();
                m_src = 2'(g);
                m_v   = 1;
                m_rr  = (g + 1) % N;
            end else begin
                m_v = 0;
            end
            for (int i = 0; i < N; i++)
                if (req_valid[i] && sz[i] < D)
                    mq[i].push_back({req_tag[i*TW +: TW], req_data[i*DW +: DW]});
        end
    endtask

    task automatic check_model();
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) er[i] = rdy && (mq[i].size() < D);
        chk("m_valid", cdb_valid, m_v);
        chk("m_tag", cdb_tag, m_tag);
        chk("m_data", cdb_data, m_data);
        chk("m_src", cdb_src, m_src);
        chk("m_conflict", conflict_cnt, m_cc);
        chk("m_ready", req_ready, er);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle();
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
        rst = 0; Clear_flag = 0; rdy = 1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); rst = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst;
        logic [2:0]  v;
        logic [11:0] t;
        logic [31:0] d;
        logic        ev;
        logic [3:0]  et;
        logic [31:0] ed;
        logic [1:0]  es;
        logic [31:0] ecc;
    } vec_t;

    vec_t vt [10];

    logic       saw_lsb_block;
    logic       s_v;
    logic [3:0] s_tag;
    logic [31:0] s_data;
    logic [1:0] s_src;
    logic [31:0] s_cc;

    initial begin
        idle();
        rst = 1;
        //          rst  v       tags     data   ev  tag  data   src  cc
        vt[0] = '{1'b1, 3'b000, 12'h000, 32'h00, 1'b0, 4'h0, 32'h00, 2'd0, 32'd0};
        vt[1] = '{1'b0, 3'b001, 12'h003, 32'h11, 1'b0, 4'h0, 32'h00, 2'd0, 32'd0};
        vt[2] = '{1'b0, 3'b000, 12'h000, 32'h00, 1'b1, 4'h3, 32'h11, 2'd0, 32'd0};
        vt[3] = '{1'b0, 3'b000, 12'h000, 32'h00, 1'b0, 4'h3, 32'h11, 2'd0, 32'd0};
        vt[4] = '{1'b1, 3'b000, 12'h000, 32'h00, 1'b0, 4'h0, 32'h00, 2'd0, 32'd0};
        vt[5] = '{1'b0, 3'b111, 12'h321, 32'h20, 1'b0, 4'h0, 32'h00, 2'd0, 32'd0};
        vt[6] = '{1'b0, 3'b000, 12'h000, 32'h00, 1'b1, 4'h1, 32'h20, 2'd0, 32'd1};
        vt[7] = '{1'b0, 3'b000, 12'h000, 32'h00, 1'b1, 4'h2, 32'h21, 2'd1, 32'd2};
        vt[8] = '{1'b0, 3'b000, 12'h000, 32'h00, 1'b1, 4'h3, 32'h22, 2'd2, 32'd2};
        vt[9] = '{1'b0, 3'b000, 12'h000, 32'h00, 1'b0, 4'h3, 32'h22, 2'd2, 32'd2};

        for (int r = 0; r < 10; r++) begin
            rst       = vt[r].rst;
            rdy       = 1;
            Clear_flag = 0;
            req_valid = vt[r].v;
            req_tag   = vt[r].t;
            req_data  = {vt[r].d + 32'd2, vt[r].d + 32'd1, vt[r].d};
            step();
            chk($sformatf("tbl%0d_valid", r), cdb_valid, vt[r].ev);
            chk($sformatf("tbl%0d_tag", r), cdb_tag, vt[r].et);
            chk($sformatf("tbl%0d_data", r), cdb_data, vt[r].ed);
            chk($sformatf("tbl%0d_src", r), cdb_src, vt[r].es);
            chk($sformatf("tbl%0d_conflict", r), conflict_cnt, vt[r].ecc);
            chk($sformatf("tbl%0d_ready", r), req_ready, 3'b111);
        end

        // Backpressure: LSB offers tags 4..7 while ALU stays busy
        do_reset();
        saw_lsb_block = 0;
        for (int c = 0; c < 4; c++) begin
            req_valid = 3'b011;
            req_tag   = {4'h0, 4'(4 + c), 4'(8 + c)};
            req_data  = {32'h0, 32'h40 + 32'(c), 32'h80 + 32'(c)};
            step();
            if (req_ready[1] == 1'b0) saw_lsb_block = 1;
        end
        chk("bp_lsb_ready_dropped", saw_lsb_block, 1'b1);
        idle();
        for (int c = 0; c < 6; c++) step();
        chk("bp_drained_valid", cdb_valid, 1'b0);

        // Flush with entries pending and a same-cycle push
        do_reset();
        req_valid = 3'b011; req_tag = 12'h0_5_6; req_data = {32'h0, 32'h55, 32'h66};
        step(); step();
        Clear_flag = 1; req_valid = 3'b001;
        step();
        chk("flush_valid", cdb_valid, 1'b0);
        chk("flush_ready0", req_ready[0], 1'b1);
        idle();
        for (int c = 0; c < 4; c++) begin
            step();
            chk("flush_quiet", cdb_valid, 1'b0);
        end

        // rdy stall with entries pending
        do_reset();
        req_valid = 3'b111; req_tag = 12'h9_a_b; req_data = {32'h99, 32'haa, 32'hbb};
        step();
        step();
        idle();
        step();
        s_v = cdb_valid; s_tag = cdb_tag; s_data = cdb_data; s_src = cdb_src; s_cc = conflict_cnt;
        chk("stall_pre_valid", s_v, 1'b1);
        rdy = 0;
        req_valid = 3'b111;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_valid", cdb_valid, s_v);
            chk("stall_tag", cdb_tag, s_tag);
            chk("stall_data", cdb_data, s_data);
            chk("stall_src", cdb_src, s_src);
            chk("stall_conflict", conflict_cnt, s_cc);
            chk("stall_ready", req_ready, 3'b000);
        end
        idle();
        step();
        chk("stall_resume_valid", cdb_valid, 1'b1);
        chk("stall_resume_src", cdb_src, 2'((s_src + 1) % N));
        for (int c = 0; c < 4; c++) step();

        // Reset in the middle of traffic
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req_valid = 3'b111;
            req_tag   = {4'(c), 4'(c + 4), 4'(c + 8)};
            req_data  = {32'hc0 + 32'(c), 32'hb0 + 32'(c), 32'ha0 + 32'(c)};
            step();
        end
        chk("mid_pre_valid", cdb_valid, 1'b1);
        chk("mid_pre_full", (req_ready != 3'b111), 1'b1);
        idle(); rst = 1;
        step();
        rst = 0;
        chk("mid_rst_valid", cdb_valid, 1'b0);
        chk("mid_rst_tag", cdb_tag, 4'h0);
        chk("mid_rst_data", cdb_data, 32'h0);
        chk("mid_rst_src", cdb_src, 2'd0);
        chk("mid_rst_conflict", conflict_cnt, 32'd0);
        chk("mid_rst_ready", req_ready, 3'b111);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("mid_rst_quiet", cdb_valid, 1'b0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            rdy        = ($urandom_range(0, 9) != 0);
            Clear_flag = ($urandom_range(0, 19) == 0);
            req_valid  = 3'($urandom);
            req_tag    = 12'($urandom);
            req_data   = {$urandom, $urandom, $urandom};
            step();
        end
        idle();
        for (int c = 0; c < 6; c++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
